// File: rtl/vga_pattern_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vga_pattern_tx
//
// Source end of the VGA link: generates 1024x768@60 timing (1344x806 total,
// 65 MHz pixel clock) together with one of four built-in test patterns. It
// can drive board pins directly, or act as a known-good reference image for
// the frame-capture path.
//
// Every output is registered from the same hc/vc state, so hcount/vcount,
// the syncs, the blanking flags, the colour and frame_start always describe
// the same pixel.
//
// Ports
//   clk          pixel clock (65 MHz)
//   rst_n        asynchronous active-low reset
//   en           advance counters; low freezes all state and outputs
//   mode[1:0]    pattern select (0 solid, 1 bars, 2 checker, 3 gradient),
//                latched on the last pixel of a frame
//   colour[11:0] {r,g,b} used by the solid pattern, latched with mode
//   hcount/vcount[10:0]  position of the current output pixel
//   hsync, vsync active-high sync pulses
//   hblnk, vblnk high outside the visible area
//   r, g, b[3:0] pixel colour, forced to 0 during blanking
//   frame_start  high while the output pixel is (0,0)
// ---------------------------------------------------------------------------
module vga_pattern_tx #(
    parameter int HOR_TOTAL      = 1344,
    parameter int HOR_ACTIVE     = 1024,
    parameter int HOR_SYNC_START = 1048,
    parameter int HOR_SYNC_END   = 1184,
    parameter int VER_TOTAL      = 806,
    parameter int VER_ACTIVE     = 768,
    parameter int VER_SYNC_START = 771,
    parameter int VER_SYNC_END   = 777
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [11:0] colour,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pattern_e;

    localparam logic [10:0] H_LAST   = 11'(HOR_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(HOR_ACTIVE);
    localparam logic [10:0] H_SYNC_S = 11'(HOR_SYNC_START);
    localparam logic [10:0] H_SYNC_E = 11'(HOR_SYNC_END);
    localparam logic [10:0] V_LAST   = 11'(VER_TOTAL - 1);
    localparam logic [10:0] V_ACT    = 11'(VER_ACTIVE);
    localparam logic [10:0] V_SYNC_S = 11'(VER_SYNC_START);
    localparam logic [10:0] V_SYNC_E = 11'(VER_SYNC_END);

    logic [10:0] hc;
    logic [10:0] vc;
    pattern_e    mode_q;
    logic [11:0] colour_q;
    logic [3:0]  fc;

    logic        line_end;
    logic        frame_end;
    logic        active;
    logic [11:0] pixel;

    assign line_end  = (hc == H_LAST);
    assign frame_end = line_end && (vc == V_LAST);
    assign active    = (hc < H_ACT) && (vc < V_ACT);

    // Raster counters plus the per-frame state. mode, colour and the frame
    // counter only move on the very last pixel, so a pattern change requested
    // mid-frame takes effect cleanly at the next (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc       <= '0;
            vc       <= '0;
            mode_q   <= PAT_SOLID;
            colour_q <= '0;
            fc       <= '0;
        end else if (en) begin
            if (line_end) begin
                hc <= '0;
                if (vc == V_LAST) begin
                    vc <= '0;
                end else begin
                    vc <= vc + 11'd1;
                end
            end else begin
                hc <= hc + 11'd1;
            end

            if (frame_end) begin
                mode_q   <= pattern_e'(mode);
                colour_q <= colour;
                fc       <= fc + 4'd1;
            end
        end
    end

    // Pattern generator for the current counter position. Blanking is
    // applied in the output stage, so this only has to describe the
    // visible area.
    always_comb begin
        pixel = 12'h000;
        unique case (mode_q)
            PAT_SOLID: begin
                pixel = colour_q;
            end
            PAT_BARS: begin
                case (hc[9:7])
                    3'd0:    pixel = 12'hFFF;
                    3'd1:    pixel = 12'hFF0;
                    3'd2:    pixel = 12'h0FF;
                    3'd3:    pixel = 12'h0F0;
                    3'd4:    pixel = 12'hF0F;
                    3'd5:    pixel = 12'hF00;
                    3'd6:    pixel = 12'h00F;
                    default: pixel = 12'h000;
                endcase
            end
            PAT_CHECKER: begin
                pixel = (hc[5] ^ vc[5]) ? 12'hFFF : 12'h000;
            end
            PAT_GRADIENT: begin
                pixel = {hc[9:6], vc[9:6], fc};
            end
        endcase
    end

    // Output stage: one register layer sampling the same hc/vc state, which
    // keeps every output aligned to the pixel reported on hcount/vcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcount      <= hc;
            vcount      <= vc;
            hsync       <= (hc >= H_SYNC_S) && (hc < H_SYNC_E);
            vsync       <= (vc >= V_SYNC_S) && (vc < V_SYNC_E);
            hblnk       <= (hc >= H_ACT);
            vblnk       <= (vc >= V_ACT);
            {r, g, b}   <= active ? pixel : 12'h000;
            frame_start <= (hc == 11'd0) && (vc == 11'd0);
        end
    end

endmodule
